// File: rtl/memory_programmer_pkg.sv
// Shared types and constants for the front-panel memory programmer.
package memory_programmer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    WRITE,
    WAIT_RELEASE,
    DEB_RELEASE
  } prog_state_t;

  localparam int unsigned RAM_ADDR_WIDTH = 4;

endpackage

// File: rtl/two_flop_synchronizer.sv
// Single-bit two-flop synchroniser for asynchronous panel inputs; resets to 0.
module two_flop_synchronizer (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/memory_programmer.sv
// Front-panel program loader: debounced write strobe, manual address pointer
// with optional auto-increment, and RAM address mux between panel and MAR.
module memory_programmer
  import memory_programmer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned ADDR_WIDTH      = RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  manual_mode_sw,
  input  logic                  write_button,
  input  logic                  auto_increment_sw,
  input  logic [ADDR_WIDTH-1:0] address_switches,
  input  logic [ADDR_WIDTH-1:0] mar_address,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  manual_read,
  output logic                  manual_mode,
  output logic [ADDR_WIDTH-1:0] manual_pointer
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic mode_s;
  logic btn_s;
  logic inc_s;

  prog_state_t           state_q;
  logic [CntW-1:0]       cnt_q;
  logic [ADDR_WIDTH-1:0] ptr_q;

  two_flop_synchronizer u_sync_mode (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (manual_mode_sw),
    .q_o  (mode_s)
  );

  two_flop_synchronizer u_sync_btn (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (write_button),
    .q_o  (btn_s)
  );

  two_flop_synchronizer u_sync_inc (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (auto_increment_sw),
    .q_o  (inc_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else if (!mode_s) begin
      // Leaving manual mode abandons any press in flight; pointer is kept.
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!inc_s) ptr_q <= address_switches;
          if (btn_s) begin
            state_q <= DEB_PRESS;
            cnt_q   <= '0;
          end
        end
        DEB_PRESS: begin
          if (!btn_s)               state_q <= IDLE;
          else if (cnt_q == CntMax) state_q <= WRITE;
          else                      cnt_q   <= cnt_q + CntW'(1);
        end
        WRITE: begin
          // RAM captures the old pointer on this same edge.
          state_q <= WAIT_RELEASE;
          if (inc_s) ptr_q <= ptr_q + ADDR_WIDTH'(1);
        end
        WAIT_RELEASE: begin
          if (!btn_s) begin
            state_q <= DEB_RELEASE;
            cnt_q   <= '0;
          end
        end
        DEB_RELEASE: begin
          if (btn_s)                state_q <= WAIT_RELEASE;
          else if (cnt_q == CntMax) state_q <= IDLE;
          else                      cnt_q   <= cnt_q + CntW'(1);
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign manual_mode    = mode_s;
  assign manual_read    = (state_q == WRITE) && mode_s;
  assign manual_pointer = ptr_q;
  assign ram_address    = mode_s ? ptr_q : mar_address;

endmodule

// File: tb/tb_memory_programmer.sv
// Bench for memory_programmer: run-length debounce model compared every cycle,
// plus directed scenarios with hand-computed strobe timing and addresses.
module tb_memory_programmer;

  localparam int D = 4;

  logic       clk;
  logic       rst_n;
  logic       manual_mode_sw;
  logic       write_button;
  logic       auto_increment_sw;
  logic [3:0] address_switches;
  logic [3:0] mar_address;
  logic [3:0] ram_address;
  logic       manual_read;
  logic       manual_mode;
  logic [3:0] manual_pointer;

  int total = 0;
  int bad   = 0;
  int strobes = 0;
  logic [3:0] strobe_addr[$];

  memory_programmer #(
    .DEBOUNCE_CYCLES(D),
    .ADDR_WIDTH     (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .manual_mode_sw   (manual_mode_sw),
    .write_button     (write_button),
    .auto_increment_sw(auto_increment_sw),
    .address_switches (address_switches),
    .mar_address      (mar_address),
    .ram_address      (ram_address),
    .manual_read      (manual_read),
    .manual_mode      (manual_mode),
    .manual_pointer   (manual_pointer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: a press is recognised after D+1 consecutive synced-high edges while
  // armed; re-arming needs D+1 consecutive synced-low edges after the strobe.
  logic m_ms1, m_ms2, m_bs1, m_bs2, m_is1, m_is2;
  int   m_phase;  // 0 armed, 1 strobe cycle, 2 waiting for release
  int   m_hi, m_lo;
  logic [3:0] m_ptr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {m_ms1, m_ms2, m_bs1, m_bs2, m_is1, m_is2} = '0;
      m_phase = 0;
      m_hi    = 0;
      m_lo    = 0;
      m_ptr   = '0;
    end else begin
      if (!m_ms2) begin
        m_phase = 0;
        m_hi    = 0;
        m_lo    = 0;
      end else if (m_phase == 0) begin
        if (m_hi == 0 && !m_is2) m_ptr = address_switches;
        if (m_bs2) begin
          m_hi++;
          if (m_hi == D + 1) m_phase = 1;
        end else begin
          m_hi = 0;
        end
      end else if (m_phase == 1) begin
        if (m_is2) m_ptr = 4'((int'(m_ptr) + 1) % 16);
        m_phase = 2;
        m_lo    = 0;
      end else begin
        if (!m_bs2) begin
          m_lo++;
          if (m_lo == D + 1) begin
            m_phase = 0;
            m_hi    = 0;
          end
        end else begin
          m_lo = 0;
        end
      end
      m_ms2 = m_ms1; m_ms1 = manual_mode_sw;
      m_bs2 = m_bs1; m_bs1 = write_button;
      m_is2 = m_is1; m_is1 = auto_increment_sw;
    end
  end

  always @(negedge clk) begin
    check("mdl_mode", manual_mode, m_ms2);
    check("mdl_read", manual_read, (m_phase == 1) && m_ms2);
    check("mdl_ptr", manual_pointer, m_ptr);
    check("mdl_ram", ram_address, m_ms2 ? m_ptr : mar_address);
    if (manual_read === 1'b1) begin
      strobes++;
      strobe_addr.push_back(ram_address);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive_btn(input logic v, input int n);
    write_button = v;
    step(n);
  endtask

  // Button goes high now; the next edge is edge 0. Strobe expected after edge idx.
  task automatic press_window(input int n, input int idx, input logic [3:0] addr);
    write_button = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      check("win_read", manual_read, (i == idx) ? 8'd1 : 8'd0);
      if (i == idx) check("win_addr", ram_address, addr);
    end
  endtask

  initial begin
    logic bounce_p[7];
    logic bounce_r[6];
    int   s0;
    int   q0;
    bounce_p = '{1, 1, 0, 1, 1, 1, 1};
    bounce_r = '{0, 1, 0, 0, 0, 0};

    rst_n = 1'b0;
    manual_mode_sw = 1'b0;
    write_button = 1'b0;
    auto_increment_sw = 1'b0;
    address_switches = 4'h0;
    mar_address = 4'h9;
    step(3);
    check("rst_ram", ram_address, 8'd9);
    check("rst_read", manual_read, 8'd0);
    check("rst_ptr", manual_pointer, 8'd0);
    check("rst_mode", manual_mode, 8'd0);

    rst_n = 1'b1;
    manual_mode_sw = 1'b1;
    address_switches = 4'h3;
    step(1);
    check("mode_early", manual_mode, 8'd0);
    step(1);
    check("mode_on", manual_mode, 8'd1);
    step(1);
    check("ram_follow", ram_address, 8'd3);

    // Clean press
    address_switches = 4'h5;
    step(2);
    s0 = strobes;
    press_window(20, D + 2, 4'h5);
    drive_btn(1'b0, 10);
    check("clean_cnt", 8'(strobes - s0), 8'd1);

    // Bounce on press and release, then a second press
    s0 = strobes;
    for (int i = 0; i < 7; i++) drive_btn(bounce_p[i], 1);
    drive_btn(1'b1, 12);
    check("bounce_cnt1", 8'(strobes - s0), 8'd1);
    for (int i = 0; i < 6; i++) drive_btn(bounce_r[i], 1);
    drive_btn(1'b0, 10);
    check("bounce_rel", 8'(strobes - s0), 8'd1);
    drive_btn(1'b1, 12);
    drive_btn(1'b0, 10);
    check("bounce_cnt2", 8'(strobes - s0), 8'd2);

    // Auto-increment wrap
    address_switches = 4'hE;
    step(3);
    check("inc_load", manual_pointer, 8'd14);
    auto_increment_sw = 1'b1;
    step(3);
    q0 = strobe_addr.size();
    for (int p = 0; p < 3; p++) begin
      drive_btn(1'b1, 10);
      drive_btn(1'b0, 10);
    end
    check("inc_cnt", 8'(strobe_addr.size() - q0), 8'd3);
    if (strobe_addr.size() == q0 + 3) begin
      check("inc_a0", strobe_addr[q0], 8'd14);
      check("inc_a1", strobe_addr[q0+1], 8'd15);
      check("inc_a2", strobe_addr[q0+2], 8'd0);
    end
    check("inc_ptr", manual_pointer, 8'd1);
    auto_increment_sw = 1'b0;
    address_switches = 4'h7;
    step(4);
    check("abort_pre", manual_pointer, 8'd7);

    // Abort by leaving manual mode mid-debounce
    s0 = strobes;
    drive_btn(1'b1, 4);
    manual_mode_sw = 1'b0;
    step(10);
    check("abort_cnt", 8'(strobes - s0), 8'd0);
    check("abort_mode", manual_mode, 8'd0);
    check("abort_ram", ram_address, 8'd9);
    check("abort_ptr", manual_pointer, 8'd7);
    manual_mode_sw = 1'b1;
    press_window(12, D + 2, 4'h7);

    // Async reset in WAIT_RELEASE with the button still held
    rst_n = 1'b0;
    #1;
    check("arst_read", manual_read, 8'd0);
    check("arst_ptr", manual_pointer, 8'd0);
    check("arst_mode", manual_mode, 8'd0);
    check("arst_ram", ram_address, 8'd9);
    step(3);
    rst_n = 1'b1;
    s0 = strobes;
    press_window(14, D + 2, 4'h7);
    check("arst_cnt", 8'(strobes - s0), 8'd1);
    drive_btn(1'b0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
